// File: rtl/vertical_counter_generator.sv
// Vertical timing stage: counts new_line pulses into frame line / scaled row counters
// and drives VSYNC, v_display and new_frame. Optional watchdog: `define LINE_WATCHDOG_EN.
module vertical_counter_generator (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_line,
  output logic [9:0] ver_cnt,
  output logic [6:0] scl_ver_cnt,
  output logic       VSYNC,
  output logic       v_display,
  output logic       new_frame,
  output logic       line_err
);

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned SCL_W    = 7;
  localparam int unsigned SUB_W    = 3;
  localparam int unsigned V_TOTAL  = 521;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 29;
  localparam int unsigned V_DISP   = 480;
  localparam int unsigned SCALE    = 5;
  localparam int unsigned V_START  = V_SYNC + V_BP;
  localparam int unsigned V_END    = V_START + V_DISP;

  typedef enum logic [1:0] {
    SYNC        = 2'd0,
    BACK_PORCH  = 2'd1,
    DISPLAY     = 2'd2,
    FRONT_PORCH = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   ver_cnt_q, ver_cnt_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [SCL_W-1:0]   scl_q, scl_d;
  logic               vsync_q, vsync_d;
  logic               v_display_q, v_display_d;
  logic               wrap_q, wrap_d;
  logic               new_frame_q, new_frame_d;

  // Line advance, phase FSM and row scaling, all keyed to the next line value
  always_comb begin
    ver_cnt_d   = ver_cnt_q;
    state_d     = state_q;
    sub_d       = sub_q;
    scl_d       = scl_q;
    wrap_d      = 1'b0;
    if (new_line) begin
      if (ver_cnt_q == CNT_W'(V_TOTAL - 1)) begin
        ver_cnt_d = '0;
        wrap_d    = 1'b1;
      end else begin
        ver_cnt_d = ver_cnt_q + CNT_W'(1);
      end
      case (state_q)
        SYNC:        if (ver_cnt_d == CNT_W'(V_SYNC))  state_d = BACK_PORCH;
        BACK_PORCH:  if (ver_cnt_d == CNT_W'(V_START)) state_d = DISPLAY;
        DISPLAY:     if (ver_cnt_d == CNT_W'(V_END))   state_d = FRONT_PORCH;
        FRONT_PORCH: if (ver_cnt_d == '0)              state_d = SYNC;
        default:                                       state_d = SYNC;
      endcase
      if (state_q == DISPLAY) begin
        if (ver_cnt_d == CNT_W'(V_END)) begin
          sub_d = '0;
          scl_d = '0;
        end else if (sub_q == SUB_W'(SCALE - 1)) begin
          sub_d = '0;
          scl_d = scl_q + SCL_W'(1);
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
    end
    vsync_d     = (ver_cnt_q >= CNT_W'(V_SYNC));
    v_display_d = (state_d == DISPLAY);
    new_frame_d = wrap_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SYNC;
      ver_cnt_q   <= '0;
      sub_q       <= '0;
      scl_q       <= '0;
      vsync_q     <= 1'b0;
      v_display_q <= 1'b0;
      wrap_q      <= 1'b0;
      new_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ver_cnt_q   <= ver_cnt_d;
      sub_q       <= sub_d;
      scl_q       <= scl_d;
      vsync_q     <= vsync_d;
      v_display_q <= v_display_d;
      wrap_q      <= wrap_d;
      new_frame_q <= new_frame_d;
    end
  end

  assign ver_cnt     = ver_cnt_q;
  assign scl_ver_cnt = scl_q;
  assign VSYNC       = vsync_q;
  assign v_display   = v_display_q;
  assign new_frame   = new_frame_q;

`ifdef LINE_WATCHDOG_EN
  localparam int unsigned WD_LIMIT = 1023;

  logic [CNT_W-1:0] wd_q, wd_d;
  logic             line_err_q, line_err_d;

  // Saturating idle-clock counter; the error flag is sticky until reset
  always_comb begin
    wd_d       = wd_q;
    line_err_d = line_err_q;
    if (new_line) begin
      wd_d = '0;
    end else if (wd_q != CNT_W'(WD_LIMIT)) begin
      wd_d = wd_q + CNT_W'(1);
    end
    if (wd_d == CNT_W'(WD_LIMIT)) line_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q       <= '0;
      line_err_q <= 1'b0;
    end else begin
      wd_q       <= wd_d;
      line_err_q <= line_err_d;
    end
  end

  assign line_err = line_err_q;
`else
  assign line_err = 1'b0;
`endif

endmodule

// File: tb/tb_vertical_counter_generator.sv
// Bench for vertical_counter_generator: frame-level arithmetic model checked every cycle,
// plus directed literal checks at the frame boundaries.
module tb_vertical_counter_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic       new_line;
  logic [9:0] ver_cnt;
  logic [6:0] scl_ver_cnt;
  logic       VSYNC;
  logic       v_display;
  logic       new_frame;
  logic       line_err;

  int n_cmp = 0;
  int n_err = 0;

  vertical_counter_generator dut (
    .clk         (clk),
    .reset       (reset),
    .new_line    (new_line),
    .ver_cnt     (ver_cnt),
    .scl_ver_cnt (scl_ver_cnt),
    .VSYNC       (VSYNC),
    .v_display   (v_display),
    .new_frame   (new_frame),
    .line_err    (line_err)
  );

  always #5 clk = ~clk;

  // Frame model: line number plus derived quantities
  int m_ver     = 0;
  bit m_vsync   = 0;
  bit m_nf      = 0;
  bit m_wrapped = 0;
  bit m_err     = 0;
  int m_idle    = 0;
  bit m_valid   = 0;

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      m_ver = 0; m_vsync = 0; m_nf = 0; m_wrapped = 0; m_err = 0; m_idle = 0;
      m_valid = 1;
    end else if (m_valid) begin
      m_vsync   = (m_ver >= 2);
      m_nf      = m_wrapped;
      m_wrapped = (new_line === 1'b1) && (m_ver == 520);
      if (new_line === 1'b1) begin
        m_ver  = (m_ver + 1) % 521;
        m_idle = 0;
      end else if (m_idle < 1023) begin
        m_idle = m_idle + 1;
      end
`ifdef LINE_WATCHDOG_EN
      if (m_idle >= 1023) m_err = 1;
`endif
    end
  end

  function automatic int exp_scl(int v);
    return (v >= 31 && v <= 510) ? (v - 31) / 5 : 0;
  endfunction

  function automatic bit exp_disp(int v);
    return (v >= 31 && v <= 510);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("ver_cnt",     32'(ver_cnt),     32'(m_ver));
      chk("scl_ver_cnt", 32'(scl_ver_cnt), 32'(exp_scl(m_ver)));
      chk("v_display",   32'(v_display),   32'(exp_disp(m_ver)));
      chk("VSYNC",       32'(VSYNC),       32'(m_vsync));
      chk("new_frame",   32'(new_frame),   32'(m_nf));
      chk("line_err",    32'(line_err),    32'(m_err));
    end
  end

  // One line: gap idle clocks, then a single new_line pulse; ends at posedge+1
  task automatic line(input int gap);
    new_line = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    new_line = 1'b1;
    @(posedge clk); #1;
    new_line = 1'b0;
  endtask

  task automatic advance_to(input int target, input int gap);
    int guard = 0;
    while (m_ver != target && guard < 600) begin
      line(gap);
      guard++;
    end
    if (m_ver != target) chk("advance_timeout", 32'(m_ver), 32'(target));
  endtask

  initial begin
    reset = 1'b1; new_line = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ver", 32'(ver_cnt), 32'd0);
    chk("rst_vsync", 32'(VSYNC), 32'd0);
    chk("rst_vdisp", 32'(v_display), 32'd0);
    chk("rst_nf", 32'(new_frame), 32'd0);

    // One full-length 800-clock line, then compressed lines
    line(799);
    @(negedge clk);
    chk("line1_ver", 32'(ver_cnt), 32'd1);
    line(3);
    @(negedge clk);
    chk("row2_vsync_lag", 32'(VSYNC), 32'd0);
    @(negedge clk);
    chk("row2_vsync", 32'(VSYNC), 32'd1);

    advance_to(30, 3);
    @(negedge clk);
    chk("row30_vdisp", 32'(v_display), 32'd0);
    line(3);
    @(negedge clk);
    chk("row31_vdisp", 32'(v_display), 32'd1);
    advance_to(35, 2);
    @(negedge clk);
    chk("row35_scl", 32'(scl_ver_cnt), 32'd0);
    line(2);
    @(negedge clk);
    chk("row36_scl", 32'(scl_ver_cnt), 32'd1);

    // Back-to-back pulses through the rest of the display
    advance_to(510, 0);
    @(negedge clk);
    chk("row510_scl", 32'(scl_ver_cnt), 32'd95);
    chk("row510_vdisp", 32'(v_display), 32'd1);
    line(1);
    @(negedge clk);
    chk("row511_scl", 32'(scl_ver_cnt), 32'd0);
    chk("row511_vdisp", 32'(v_display), 32'd0);

    advance_to(520, 1);
    line(3);
    @(negedge clk);
    chk("wrap_ver", 32'(ver_cnt), 32'd0);
    chk("wrap_nf_early", 32'(new_frame), 32'd0);
    chk("wrap_vsync_lag", 32'(VSYNC), 32'd1);
    @(negedge clk);
    chk("wrap_nf", 32'(new_frame), 32'd1);
    chk("wrap_vsync", 32'(VSYNC), 32'd0);
    @(negedge clk);
    chk("wrap_nf_width", 32'(new_frame), 32'd0);

    // Mid-frame reset colliding with new_line
    advance_to(300, 0);
    @(negedge clk);
    chk("row300_scl", 32'(scl_ver_cnt), 32'd53);
    @(posedge clk); #1;
    reset = 1'b1; new_line = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; new_line = 1'b0;
    @(negedge clk);
    chk("mrst_ver", 32'(ver_cnt), 32'd0);
    chk("mrst_scl", 32'(scl_ver_cnt), 32'd0);
    chk("mrst_vsync", 32'(VSYNC), 32'd0);
    chk("mrst_vdisp", 32'(v_display), 32'd0);
    chk("mrst_nf", 32'(new_frame), 32'd0);

    // Long idle stretch: counters frozen
    advance_to(3, 2);
    repeat (2000) @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle_ver", 32'(ver_cnt), 32'd3);
`ifdef LINE_WATCHDOG_EN
    chk("idle_err", 32'(line_err), 32'd1);
`else
    chk("idle_err", 32'(line_err), 32'd0);
`endif
    line(2);
    @(negedge clk);
    chk("resume_ver", 32'(ver_cnt), 32'd4);
`ifdef LINE_WATCHDOG_EN
    chk("resume_err", 32'(line_err), 32'd1);
`else
    chk("resume_err", 32'(line_err), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
